pio_in_capture: RTL and testbench
=================================

PIO_IN_CAPTURE -- requirements
Module: pio_in_capture

Interface
REQ-001 Parameter WIDTH, default 8, is the input port width (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth (2..4).
REQ-003 Parameter EDGE_TYPE, default 0, selects the captured edge: 0 rising, 1 falling, 2 any.
REQ-004 clk  input  1  clock; all state SHALL be on its rising edge.
REQ-005 reset_n  input  1  reset; asynchronous, active-low.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data; combinational from address, zero wait states.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 in_port SHALL pass through a SYNC_STAGES flop chain; the last stage is sync_q.
REQ-014 Register map (bits above WIDTH read 0): 0 DATA (RO) = sync_q; 1 reserved, reads 0; 2 IRQMASK (RW); 3 EDGECAP (R, write-1-to-clear).
REQ-015 A write is chipselect=1 and write_n=0 sampled at the clk edge; writes to 0 or 1 SHALL have no effect.
REQ-016 prev_q SHALL register sync_q every cycle; edge_det[i] SHALL follow EDGE_TYPE: rising = sync_q & ~prev_q; falling = ~sync_q & prev_q; any = sync_q ^ prev_q.
REQ-017 EDGECAP bit i SHALL set on the cycle after edge_det[i]=1 and stay set until cleared.
REQ-018 Latency: an in_port change SHALL be visible in DATA after SYNC_STAGES edges and in EDGECAP after SYNC_STAGES+1 edges.
REQ-019 A write to address 3 SHALL clear each EDGECAP bit whose writedata bit is 1; other bits are unaffected.
REQ-020 Simultaneous edge and clear on the same bit in the same cycle: the set SHALL win.
REQ-021 An arm counter SHALL count SYNC_STAGES+1 cycles after reset release; edge_det SHALL be forced to 0 until the count completes, then armed stays 1 until reset.
REQ-022 irq SHALL be registered: irq <= |(EDGECAP & IRQMASK), asserting one cycle after the EDGECAP bit sets.
REQ-023 Changing IRQMASK SHALL affect irq on the following cycle and SHALL NOT alter EDGECAP.

Reset
REQ-024 On reset_n=0, synchronizer stages, prev_q, EDGECAP, IRQMASK, arm counter and irq SHALL go to 0 immediately; readdata then reads 0 at every address.
REQ-025 Reset mid-operation SHALL discard pending captures; no edge is reported for input levels present at reset release.

Configuration
REQ-026 Macro PIO_IN_IRQ_EN: when defined, IRQMASK and irq SHALL behave per REQ-022/023.
REQ-027 When PIO_IN_IRQ_EN is undefined, IRQMASK SHALL not exist and SHALL read 0, writes to address 2 SHALL be ignored, and irq SHALL be tied 0; edge capture remains.

Structure
REQ-028 Package pio_in_pkg SHALL hold register offset constants (DATA, RSVD, IRQMASK, EDGECAP) and EDGE_TYPE encodings (RISING, FALLING, ANY).
REQ-029 Sub-module pio_in_sync SHALL implement the parameterized WIDTH x SYNC_STAGES synchronizer; all other logic SHALL be in pio_in_capture.

Verification
REQ-030 Reset release with in_port=8'hFF held -> EDGECAP stays 8'h00 and irq=0 after 10 cycles; DATA reads 8'hFF.
REQ-031 EDGE_TYPE=0, in_port bit 3 rising 0->1 -> DATA bit 3 = 1 after 2 edges; EDGECAP = 8'h08 after 3 edges; falling edge adds nothing.
REQ-032 IRQMASK=8'h08, bit 3 rising -> irq=1 one cycle after EDGECAP sets; write 8'h08 to address 3 -> EDGECAP=0 and irq=0 on the next cycle.
REQ-033 Edge on bit 0 in the same cycle as a write of 8'h01 to address 3 -> EDGECAP bit 0 stays 1.
REQ-034 EDGE_TYPE=2, bit 5 toggles 0->1->0 with 5-cycle spacing -> EDGECAP bit 5 set after each transition; reads at address 1 return 0.
REQ-035 Build without PIO_IN_IRQ_EN: write 8'hFF to address 2 and then an edge -> address 2 reads 0, irq stays 0, EDGECAP updates normally.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared constants for the PIO input capture block: register offsets and edge-select codes.
// No logic or state here.
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_sync.sv
// Purpose: WIDTH x STAGES flop-chain synchronizer for asynchronous inputs.
// Latency: STAGES clk edges from din to sync_q.
// Backpressure: none; free-running every cycle.
module pio_in_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync_q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_q = stage_q[STAGES-1];

endmodule

// File: rtl/pio_in_capture.sv
// Purpose: Avalon-MM PIO input port with edge capture and optional IRQ (macro PIO_IN_IRQ_EN).
// Latency: DATA after SYNC_STAGES edges, EDGECAP after SYNC_STAGES+1, irq one edge after EDGECAP.
// Backpressure: none; zero-wait-state combinational reads, writes take effect at the sampling edge.
module pio_in_capture
    import pio_in_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q,    prev_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic             wr_en;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] irqmask_rd;
    logic             unused_wdata;

    pio_in_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .sync_q  (sync_q)
    );

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Edges are masked until the synchronizer and prev_q hold post-reset samples,
    // so levels present at reset release never look like transitions.
    always_comb begin
        armed     = (arm_cnt_q == ARM_CNT);
        arm_cnt_d = arm_cnt_q;
        if (!armed) begin
            arm_cnt_d = arm_cnt_q + 3'd1;
        end

        case (EDGE_TYPE)
            EDGE_FALLING: edge_raw = ~sync_q & prev_q;
            EDGE_ANY:     edge_raw = sync_q ^ prev_q;
            default:      edge_raw = sync_q & ~prev_q;
        endcase
        edge_det = armed ? edge_raw : '0;

        clr_mask = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr_mask = writedata[WIDTH-1:0];
        end

        prev_d    = sync_q;
        edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            edgecap_q <= '0;
            arm_cnt_q <= '0;
        end else begin
            prev_q    <= prev_d;
            edgecap_q <= edgecap_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

`ifdef PIO_IN_IRQ_EN
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic             irq_q,     irq_d;

    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        irq_d = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irqmask_q <= irqmask_d;
            irq_q     <= irq_d;
        end
    end

    assign irqmask_rd = irqmask_q;
    assign irq        = irq_q;
`else
    assign irqmask_rd = '0;
    assign irq        = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_q;
            ADDR_RSVD:    readdata            = '0;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_rd;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata            = '0;
        endcase
    end

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: a rising-edge and an any-edge instance share one bus and input.
// Expectations for irq/IRQMASK follow whether PIO_IN_IRQ_EN is defined for the build.
module tb_pio_in_capture;

`ifdef PIO_IN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd2;
    logic        irq0, irq2;

    int n_checks = 0;
    int n_errors = 0;

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_dut_rise (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd0),
        .in_port    (in_port),
        .irq        (irq0)
    );

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd2),
        .in_port    (in_port),
        .irq        (irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_addr(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        write_n    = 1'b1;
        chipselect = 1'b0;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b1;
        in_port    = 8'hFF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset with all inputs high: every address reads 0
        #2 reset_n = 1'b0;
        for (int a = 0; a < 4; a++) begin
            set_addr(2'(a));
            check("rst_rd_rise", rd0, 32'h0);
            check("rst_rd_any", rd2, 32'h0);
        end
        check("rst_irq", {31'b0, irq0}, 32'h0);
        step(2);

        // Release with inputs held high: no spurious capture
        reset_n = 1'b1;
        step(10);
        set_addr(2'd3);
        check("arm_edgecap_rise", rd0, 32'h0);
        check("arm_edgecap_any", rd2, 32'h0);
        check("arm_irq", {31'b0, irq0}, 32'h0);
        set_addr(2'd0);
        check("arm_data", rd0, 32'h0000_00FF);

        // Falling on all bits: only the any-edge instance captures
        in_port = 8'h00;
        step(5);
        set_addr(2'd3);
        check("fall_rise_none", rd0, 32'h0);
        check("fall_any_all", rd2, 32'h0000_00FF);
        wr(2'd3, 32'h0000_00FF);
        set_addr(2'd3);
        check("clr_all_any", rd2, 32'h0);

        wr(2'd2, 32'h0000_0008);
        set_addr(2'd2);
        check("mask_rd", rd0, IRQ_EN ? 32'h8 : 32'h0);

        // Bit 3 rising: DATA after 2 edges, EDGECAP after 3, irq after 4
        in_port = 8'h08;
        step(1);
        set_addr(2'd0);
        check("lat_data_1", rd0, 32'h0);
        step(1);
        set_addr(2'd0);
        check("lat_data_2", rd0, 32'h8);
        set_addr(2'd3);
        check("lat_cap_2", rd0, 32'h0);
        step(1);
        set_addr(2'd3);
        check("lat_cap_3", rd0, 32'h8);
        check("lat_irq_3", {31'b0, irq0}, 32'h0);
        step(1);
        check("lat_irq_4", {31'b0, irq0}, IRQ_EN ? 32'h1 : 32'h0);

        // Write-1-to-clear, irq follows one cycle later
        wr(2'd3, 32'h0000_0008);
        set_addr(2'd3);
        check("w1c_cap", rd0, 32'h0);
        step(1);
        check("w1c_irq", {31'b0, irq0}, 32'h0);

        // Falling on bit 3: rising instance ignores it
        in_port = 8'h00;
        step(4);
        set_addr(2'd3);
        check("fall3_rise", rd0, 32'h0);
        check("fall3_any", rd2, 32'h8);
        check("fall3_irq", {31'b0, irq0}, 32'h0);
        wr(2'd3, 32'h0000_00FF);

        // Edge on bit 0 coincides with its clear: set wins
        in_port = 8'h01;
        step(2);
        wr(2'd3, 32'h0000_0001);
        set_addr(2'd3);
        check("set_wins", rd0, 32'h1);
        wr(2'd3, 32'h0000_0001);
        set_addr(2'd3);
        check("set_wins_clr", rd0, 32'h0);
        check("set_wins_irq", {31'b0, irq0}, 32'h0);

        // Any-edge: bit 5 rises then falls, each captured
        in_port = 8'h21;
        step(5);
        set_addr(2'd3);
        check("any_rise5", rd2, 32'h20);
        check("rise_rise5", rd0, 32'h20);
        wr(2'd3, 32'h0000_0020);
        in_port = 8'h01;
        step(5);
        set_addr(2'd3);
        check("any_fall5", rd2, 32'h20);
        check("rise_fall5", rd0, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        set_addr(2'd1);
        check("rsvd_rise", rd0, 32'h0);
        check("rsvd_any", rd2, 32'h0);
        set_addr(2'd0);
        check("data_after_rsvd", rd0, 32'h1);
        wr(2'd3, 32'h0000_00FF);

        // Full mask then edge on bit 1
        wr(2'd2, 32'h0000_00FF);
        in_port = 8'h03;
        step(4);
        set_addr(2'd2);
        check("mask_ff_rd", rd0, IRQ_EN ? 32'hFF : 32'h0);
        set_addr(2'd3);
        check("mask_ff_cap", rd0, 32'h2);
        check("mask_ff_irq", {31'b0, irq0}, IRQ_EN ? 32'h1 : 32'h0);

        // Reset while a rising edge on bit 2 is in the synchronizer
        in_port = 8'h07;
        step(1);
        #2 reset_n = 1'b0;
        #1;
        set_addr(2'd3);
        check("mid_rst_cap", rd0, 32'h0);
        check("mid_rst_irq", {31'b0, irq0}, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(10);
        set_addr(2'd3);
        check("post_rst_cap_rise", rd0, 32'h0);
        check("post_rst_cap_any", rd2, 32'h0);
        set_addr(2'd0);
        check("post_rst_data", rd0, 32'h7);
        set_addr(2'd2);
        check("post_rst_mask", rd0, 32'h0);

        in_port = 8'h0F;
        step(4);
        set_addr(2'd3);
        check("post_rst_edge", rd0, 32'h8);
        check("post_rst_irq", {31'b0, irq0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
